// File: rtl/fnd_scan_ctrl_pkg.sv
// Shared FND constants, types and helpers: seg7 fonts, BCD saturation limit, double-dabble step.
package fnd_scan_ctrl_pkg;

   localparam int         VAL_W     = 14;
   localparam logic [7:0] FND_BLANK = 8'hFF;
   localparam logic [VAL_W-1:0] BCD_MAX = 14'd9999;

   // Active-low {g,f,e,d,c,b,a}; bit 7 of the full font carries the decimal point.
   localparam logic [6:0] FONT_0   = 7'h40;
   localparam logic [6:0] FONT_1   = 7'h79;
   localparam logic [6:0] FONT_2   = 7'h24;
   localparam logic [6:0] FONT_3   = 7'h30;
   localparam logic [6:0] FONT_4   = 7'h19;
   localparam logic [6:0] FONT_5   = 7'h12;
   localparam logic [6:0] FONT_6   = 7'h02;
   localparam logic [6:0] FONT_7   = 7'h78;
   localparam logic [6:0] FONT_8   = 7'h00;
   localparam logic [6:0] FONT_9   = 7'h10;
   localparam logic [6:0] FONT_ERR = 7'h7F;

   typedef logic [3:0]      bcd_t;
   typedef bcd_t [3:0]      digits_t;

   function automatic logic [6:0] seg7(input bcd_t n);
      case (n)
         4'd0:    seg7 = FONT_0;
         4'd1:    seg7 = FONT_1;
         4'd2:    seg7 = FONT_2;
         4'd3:    seg7 = FONT_3;
         4'd4:    seg7 = FONT_4;
         4'd5:    seg7 = FONT_5;
         4'd6:    seg7 = FONT_6;
         4'd7:    seg7 = FONT_7;
         4'd8:    seg7 = FONT_8;
         4'd9:    seg7 = FONT_9;
         default: seg7 = FONT_ERR;
      endcase
   endfunction

   function automatic bcd_t add3(input bcd_t n);
      add3 = (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Display-side signal bundle of fnd_scan_ctrl: control/data in, scan index, font and overflow out.
interface fnd_scan_ctrl_if;
   import fnd_scan_ctrl_pkg::*;

   logic             i_en;
   logic [VAL_W-1:0] i_value;
   logic [3:0]       i_dp;
   logic [1:0]       o_cnt4;
   logic [7:0]       o_fndfont;
   logic             o_ovf;

   modport master (output i_en, i_value, i_dp, input o_cnt4, o_fndfont, o_ovf);
   modport slave  (input i_en, i_value, i_dp, output o_cnt4, o_fndfont, o_ovf);
endinterface

// File: rtl/fnd_scan_ctrl_bcd_to_fnd.sv
// Combinational BCD digit + decimal point to active-low 8-bit segment font {dp,g..a}.
module bcd_to_fnd
   import fnd_scan_ctrl_pkg::*;
(
   input  bcd_t       bcd,
   input  logic       dp,
   output logic [7:0] font
);
   assign font = {~dp, seg7(bcd)};
endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit FND scanner: prescaled digit index, sequential 14-bit double-dabble, leading-zero blanking.
// New value reaches the display registers 15 cycles after a frame start; the font output is registered.
module fnd_scan_ctrl
   import fnd_scan_ctrl_pkg::*;
#(
   parameter int CLK_HZ   = 100_000_000,
   parameter int SCAN_HZ  = 1_000,
   parameter int LZ_BLANK = 1
)(
   input  logic           i_clk,
   input  logic           i_reset_n,
   fnd_scan_ctrl_if.slave bus
);
   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CONVERT = 2'd1;
   localparam logic [1:0] LATCH   = 2'd2;

   logic [PW-1:0]    presc;
   logic [1:0]       cnt4;
   logic [1:0]       state;
   logic [3:0]       bit_cnt;
   logic [29:0]      shreg;
   logic [29:0]      dabbled;
   logic             ovf_next;
   logic             ovf;
   digits_t          disp;
   logic [7:0]       font_q;
   logic [7:0]       font_w;
   logic             blank;
   logic [VAL_W-1:0] sat_value;

   wire tick        = (presc == PRESC_MAX);
   wire frame_start = tick && (cnt4 == 2'd3);

   assign sat_value = (bus.i_value > BCD_MAX) ? BCD_MAX : bus.i_value;

   // Upper 16 bits hold the BCD accumulator; correct each nibble before the shift.
   always_comb begin
      dabbled = shreg;
      for (int i = 0; i < 4; i++)
         dabbled[14 + 4*i +: 4] = add3(shreg[14 + 4*i +: 4]);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         presc <= '0;
         cnt4  <= 2'd0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick)
            cnt4 <= cnt4 + 2'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state    <= IDLE;
         bit_cnt  <= 4'd0;
         shreg    <= '0;
         ovf_next <= 1'b0;
         ovf      <= 1'b0;
         disp     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (frame_start) begin
                  shreg    <= {16'd0, sat_value};
                  ovf_next <= (bus.i_value > BCD_MAX);
                  bit_cnt  <= 4'd0;
                  state    <= CONVERT;
               end
            end
            CONVERT: begin
               shreg   <= {dabbled[28:0], 1'b0};
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd13)
                  state <= LATCH;
            end
            LATCH: begin
               disp  <= shreg[29:14];
               ovf   <= ovf_next;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A digit is blank when it and every more-significant digit are zero.
   always_comb begin
      blank = 1'b0;
      if (LZ_BLANK != 0) begin
         case (cnt4)
            2'd1:    blank = (disp[3:1] == 12'd0);
            2'd2:    blank = (disp[3:2] == 8'd0);
            2'd3:    blank = (disp[3] == 4'd0);
            default: blank = 1'b0;
         endcase
      end
   end

   bcd_to_fnd u_font (
      .bcd  (disp[cnt4]),
      .dp   (bus.i_dp[cnt4]),
      .font (font_w)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)
         font_q <= FND_BLANK;
      else
         font_q <= (!bus.i_en || blank) ? FND_BLANK : font_w;
   end

   assign bus.o_cnt4    = cnt4;
   assign bus.o_fndfont = font_q;
   assign bus.o_ovf     = ovf;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: a cycle-count reference model queues expected outputs, a monitor compares.
module tb_fnd_scan_ctrl;

   typedef struct {
      int         cnt;
      logic [7:0] font;
      logic       ovf;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   fnd_scan_ctrl_if bus ();

   fnd_scan_ctrl #(.CLK_HZ(3200), .SCAN_HZ(100), .LZ_BLANK(1)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   exp_t exp_q [$];

   // Reference state: edges since reset release, displayed value, pending conversion.
   int n        = 0;
   int disp_v   = 0;
   int pend_v   = 0;
   int latch_at = -1;
   bit busy     = 0;
   bit m_ovf    = 0;
   bit pend_ovf = 0;

   function automatic logic [7:0] ref_font(int idx, int v, logic en, logic [3:0] dp);
      int pw = 1;
      for (int k = 0; k < idx; k++) pw = pw * 10;
      if (!en) return 8'hFF;
      if (idx > 0 && v < pw) return 8'hFF;
      return {~dp[idx], seg_tab[(v / pw) % 10]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n = 0; disp_v = 0; m_ovf = 0; busy = 0; latch_at = -1;
         exp_q.delete();
      end else begin
         exp_t e;
         int   idx;
         idx    = (n / 32) % 4;
         e.font = ref_font(idx, disp_v, bus.i_en, bus.i_dp);
         if (n == latch_at) begin
            disp_v = pend_v;
            m_ovf  = pend_ovf;
            busy   = 0;
         end
         if (n % 128 == 127 && !busy) begin
            pend_v   = (int'(bus.i_value) > 9999) ? 9999 : int'(bus.i_value);
            pend_ovf = (int'(bus.i_value) > 9999);
            latch_at = n + 15;
            busy     = 1;
         end
         n     = n + 1;
         e.cnt = (n / 32) % 4;
         e.ovf = m_ovf;
         exp_q.push_back(e);
      end
   end

   task automatic check(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_cnt4", int'(bus.o_cnt4), 0);
         check("rst_font", int'(bus.o_fndfont), 'hFF);
         check("rst_ovf", int'(bus.o_ovf), 0);
      end else if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("cnt4", int'(bus.o_cnt4), e.cnt);
         check("font", int'(bus.o_fndfont), int'(e.font));
         check("ovf", int'(bus.o_ovf), int'(e.ovf));
      end
   end

   task automatic step(int cycles);
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_phase(int ph);
      for (int k = 0; k < 300; k++) begin
         if (n % 128 == ph) return;
         step(1);
      end
      n_cmp++;
      n_err++;
      $display("FAIL wait_phase: phase %0d not reached, now %0d", ph, n % 128);
   endtask

   task automatic set_in(int v, logic [3:0] dp, logic en);
      bus.i_value = 14'(v);
      bus.i_dp    = dp;
      bus.i_en    = en;
   endtask

   initial begin
      set_in(0, 4'b0000, 1'b1);
      step(5);
      rst_n = 1'b1;
      step(300);
      set_in(1234, 4'b0000, 1'b1);  step(300);
      set_in(7,    4'b0010, 1'b1);  step(300);
      set_in(70,   4'b0000, 1'b1);  step(300);
      set_in(12000, 4'b0101, 1'b1); step(300);
      set_in(5,    4'b0000, 1'b1);  step(300);
      set_in(9876, 4'b1000, 1'b1);  step(60);
      bus.i_en = 1'b0;              step(90);
      bus.i_en = 1'b1;              step(100);
      set_in(4321, 4'b0000, 1'b1);  step(300);
      wait_phase(60);
      bus.i_value = 14'd8;          step(300);
      set_in(4321, 4'b0000, 1'b1);  step(130);
      wait_phase(5);
      rst_n = 1'b0;                 step(3);
      rst_n = 1'b1;                 step(300);
      for (int r = 0; r < 25; r++) begin
         set_in(int'($urandom_range(0, 16383)), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 4) != 0));
         if (r % 3 == 0) bus.i_value = 14'($urandom_range(0, 120));
         step(int'($urandom_range(40, 300)));
      end
      step(10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
